// File: rtl/rave_fetch_pkg.sv
// rave_fetch_pkg
//   Shared widths and helpers for the fetch -> decode hand-off.
//   PKT_W      : instruction-byte packet width (16 bytes)
//   EIP_W      : instruction pointer width
//   LEN_W      : instruction length field width (legal lengths 1..15)
//   FIFO_DEPTH : packet buffer depth between fetch and decode
package rave_fetch_pkg;

  localparam int PKT_W      = 128;
  localparam int EIP_W      = 32;
  localparam int LEN_W      = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef logic [PKT_W-1:0] pkt_t;
  typedef logic [EIP_W-1:0] eip_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Which source, if any, redirects the instruction stream this cycle.
  typedef enum logic [1:0] {
    CTL_RUN     = 2'd0,
    CTL_INIT    = 2'd1,
    CTL_RESTEER = 2'd2
  } ctl_e;

  // Advance the instruction pointer by one instruction; wraps modulo 2^EIP_W.
  function automatic eip_t eip_advance(input eip_t eip, input len_t len);
    return eip + eip_t'(len);
  endfunction

endpackage

// File: rtl/pkt_fifo2.sv
// pkt_fifo2
//   Two-entry packet buffer with synchronous flush.
//   clk      : clock, rising edge
//   reset    : synchronous active-low reset (control state only)
//   i_push   : write i_data at the tail (ignored when full or flushing)
//   i_pop    : advance the head (ignored when empty or flushing)
//   i_flush  : discard all entries; wins over push/pop
//   i_data   : packet to write
//   o_head   : head entry (don't-care when o_count == 0)
//   o_count  : occupancy 0..FIFO_DEPTH
module pkt_fifo2
  import rave_fetch_pkg::*;
#(
  parameter int DATA_W = PKT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output cnt_t              o_count
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  cnt_t              r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_full  = (r_count == cnt_t'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // Local guards keep the storage consistent even if a caller misbehaves.
  assign w_push = i_push && !w_full  && !i_flush;
  assign w_pop  = i_pop  && !w_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (i_flush) begin
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Packet storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/decode_fetch_rx.sv
// decode_fetch_rx
//   Receives instruction-byte packets from fetch, buffers them in a 2-entry
//   FIFO and presents the head packet to decode. Tracks the EIP of the head
//   instruction and returns the consumed length to fetch.
//   clk / reset            : clock and synchronous active-low reset
//   packet_in(_valid)      : packet offered by fetch
//   stall_out              : FIFO full; an offered packet is not taken
//   instr_out / instr_valid: head packet to decode
//   consume / instr_length : decode takes the head instruction of given length
//   D_length(_valid)       : length of last consumed instruction, 1-cycle pulse
//   D_EIP                  : EIP of the head instruction
//   resteer / resteer_addr : writeback redirect (flush + load EIP)
//   is_init / init_addr    : initialisation load (flush + load EIP), beats resteer
//   len_err                : sticky, set by a zero-length consume
module decode_fetch_rx
  import rave_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [PKT_W-1:0] packet_in,
  input  logic             packet_in_valid,
  output logic             stall_out,
  output logic [PKT_W-1:0] instr_out,
  output logic             instr_valid,
  input  logic             consume,
  input  logic [LEN_W-1:0] instr_length,
  output logic [LEN_W-1:0] D_length,
  output logic             D_length_valid,
  output logic [EIP_W-1:0] D_EIP,
  input  logic             resteer,
  input  logic [EIP_W-1:0] resteer_addr,
  input  logic             is_init,
  input  logic [EIP_W-1:0] init_addr,
  output logic             len_err
);

  cnt_t w_count;
  pkt_t w_head;
  ctl_e w_ctl;
  logic w_flush;
  logic w_push;
  logic w_take;
  logic w_pop;
  logic w_zero_len;

  eip_t r_eip;
  len_t r_len;
  logic r_len_vld;
  logic r_len_err;

  // Redirect priority: init beats resteer, both beat normal traffic.
  always_comb begin
    w_ctl = CTL_RUN;
    if (is_init)      w_ctl = CTL_INIT;
    else if (resteer) w_ctl = CTL_RESTEER;
  end

  assign w_flush = (w_ctl != CTL_RUN);

  // Stall comes from registered occupancy only, so a full FIFO refuses a
  // packet even in a cycle where decode frees an entry.
  assign stall_out   = (w_count == cnt_t'(FIFO_DEPTH));
  assign instr_valid = (w_count != '0);
  assign instr_out   = w_head;

  assign w_push     = packet_in_valid && !stall_out && !w_flush;
  assign w_take     = consume && instr_valid && !w_flush;
  assign w_pop      = w_take && (instr_length != '0);
  assign w_zero_len = w_take && (instr_length == '0);

  pkt_fifo2 #(
    .DATA_W (PKT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (packet_in),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_eip     <= '0;
      r_len     <= '0;
      r_len_vld <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_len_vld <= 1'b0;
      case (w_ctl)
        CTL_INIT:    r_eip <= init_addr;
        CTL_RESTEER: r_eip <= resteer_addr;
        default: begin
          if (w_pop) begin
            r_eip     <= eip_advance(r_eip, instr_length);
            r_len     <= instr_length;
            r_len_vld <= 1'b1;
          end
          if (w_zero_len) r_len_err <= 1'b1;
        end
      endcase
    end
  end

  assign D_EIP          = r_eip;
  assign D_length       = r_len;
  assign D_length_valid = r_len_vld;
  assign len_err        = r_len_err;

endmodule

// File: doc/decode_fetch_rx.md
DECODE_FETCH_RX -- requirements
Module: decode_fetch_rx

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have `packet_in`, input, 128 bits: instruction-byte packet from fetch; byte 0 is in bits [7:0].
REQ-004 SHALL have `packet_in_valid`, input, 1 bit: `packet_in` carries a packet this cycle.
REQ-005 SHALL have `stall_out`, output, 1 bit: back-pressure to fetch; a packet offered while it is high is not taken.
REQ-006 SHALL have `instr_out`, output, 128 bits: head packet presented to the decode stage.
REQ-007 SHALL have `instr_valid`, output, 1 bit: `instr_out` is valid.
REQ-008 SHALL have `consume`, input, 1 bit: decode accepts the head instruction this cycle.
REQ-009 SHALL have `instr_length`, input, 4 bits: byte length of the head instruction from the length decoder; legal range 1..15.
REQ-010 SHALL have `D_length`, output, 4 bits: registered length of the last consumed instruction, returned to fetch.
REQ-011 SHALL have `D_length_valid`, output, 1 bit: one-cycle pulse qualifying `D_length`.
REQ-012 SHALL have `D_EIP`, output, 32 bits: EIP of the head instruction.
REQ-013 SHALL have `resteer` (input, 1 bit) and `resteer_addr` (input, 32 bits): writeback redirect.
REQ-014 SHALL have `is_init` (input, 1 bit) and `init_addr` (input, 32 bits): initialisation load.
REQ-015 SHALL have `len_err`, output, 1 bit: sticky flag raised on a zero-length consume.

Function
REQ-016 SHALL buffer packets in a 2-entry FIFO with an occupancy count of 0..2.
REQ-017 SHALL drive `stall_out` = (count == 2), combinationally from registered state.
REQ-018 SHALL push `packet_in` when `packet_in_valid` && !`stall_out`.
REQ-019 SHALL drive `instr_valid` = (count != 0), with `instr_out` = the head entry; latency from push to visible at the head is 1 cycle.
REQ-020 SHALL perform a pop when `consume` && `instr_valid` && `instr_length` != 0; a pop advances the head, sets `D_EIP` <= `D_EIP` + `instr_length` (mod 2^32, wrap from 0xFFFFFFFF permitted), loads `D_length` <= `instr_length`, and pulses `D_length_valid` for 1 cycle.
REQ-021 SHALL, on a push and a pop in the same cycle, leave the count unchanged; at count 1 the new packet becomes the head on the next cycle.
REQ-022 SHALL, at count 2, not accept a new packet even if a pop occurs that cycle, because `stall_out` is registered-state based.
REQ-023 SHALL ignore `consume` when `instr_valid` = 0, with no state change.
REQ-024 SHALL, on `consume` with `instr_length` == 0: perform no pop, leave `D_EIP` unchanged, and set `len_err` = 1, which holds until reset.
REQ-025 SHALL, when `is_init` = 1: flush the FIFO (count <= 0), load `D_EIP` <= `init_addr`, drop any same-cycle push and pop, and hold `D_length_valid` = 0.
REQ-026 SHALL, when `resteer` = 1 and `is_init` = 0: apply the same flush with `D_EIP` <= `resteer_addr`.
REQ-027 SHALL give priority `reset` > `is_init` > `resteer` > push/pop.
REQ-028 SHALL keep FIFO read and write pointers 1 bit wide, each toggling on its operation.

Reset
REQ-029 SHALL, when `reset` = 0 at a clock edge, set: count = 0; both pointers = 0; `D_EIP` = 0; `D_length` = 0; `D_length_valid` = 0; `len_err` = 0; resulting in `instr_valid` = 0 and `stall_out` = 0.
REQ-030 SHALL, on reset mid-operation, discard buffered packets; `instr_out` contents are don't-care while `instr_valid` = 0.

Structure
REQ-031 SHALL take PKT_W = 128, EIP_W = 32, LEN_W = 4 and FIFO_DEPTH = 2 from the shared package rave_fetch_pkg.
REQ-032 SHALL implement the storage as sub-module pkt_fifo2 (2 × 128-bit entries, push/pop/flush, count); the EIP and length logic lives in the top module.

Verification
REQ-033 SHALL cover: `is_init` with `init_addr` = 0x0000_1000, then push P0 -> next cycle `instr_valid` = 1, `instr_out` = P0, `D_EIP` = 0x1000.
REQ-034 SHALL cover: push P0 and P1 with no consume -> `stall_out` = 1; an offered P2 is dropped; consume with length 3 -> `D_EIP` = 0x1003, `D_length` = 3 with a 1-cycle `D_length_valid` pulse, head = P1.
REQ-035 SHALL cover: count 1 with push P1 and consume (length 5) in the same cycle -> count stays 1, head = P1, `D_EIP` += 5.
REQ-036 SHALL cover: FIFO full, `resteer` = 1 with `resteer_addr` = 0x2000 and a same-cycle push -> count = 0, `D_EIP` = 0x2000, push dropped; `is_init` and `resteer` together -> `init_addr` wins.
REQ-037 SHALL cover: `D_EIP` = 0xFFFF_FFFE, consume with length 4 -> `D_EIP` = 0x0000_0002.
REQ-038 SHALL cover: consume with `instr_length` = 0 -> `len_err` = 1 and sticky, no pop; then `reset` = 0 for 1 cycle -> all outputs at their reset values.
